jtag_dual_user_dr: RTL and testbench



---
 rtl/jtag_dual_user_dr_pkg.sv | 18 +
 rtl/jtag_dual_user_dr_if.sv | 40 ++++
 rtl/jtag_user_dr_chan.sv | 74 +++++++
 rtl/jtag_dual_user_dr.sv | 121 ++++++++++++
 tb/tb_jtag_dual_user_dr.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dual_user_dr_pkg.sv
// Shared definitions for the dual-channel JTAG user data-register engine.
package jtag_user_pkg;

  // Which user register owns the pending update.
  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_1    = 2'd1,
    CH_2    = 2'd2
  } ch_sel_e;

  localparam int unsigned DR_WIDTH_DEF = 16;

  // The counter must reach DR_WIDTH+1 so an over-long shift can be told apart.
  function automatic int unsigned cnt_w_f(input int unsigned dr_width);
    return $clog2(dr_width + 2);
  endfunction

endpackage

// File: rtl/jtag_dual_user_dr_if.sv
// JTAGG-side and application-side signals of the dual user DR engine.
interface jtag_dual_user_dr_if
  import jtag_user_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF
);
  logic                JTDI;
  logic                JSHIFT;
  logic                JUPDATE;
  logic                JCE1;
  logic                JCE2;
  logic                JRTI1;
  logic                JRTI2;
  logic                JTDO1;
  logic                JTDO2;
  logic [DR_WIDTH-1:0] cap_data1;
  logic [DR_WIDTH-1:0] cap_data2;
  logic [DR_WIDTH-1:0] upd_data1;
  logic [DR_WIDTH-1:0] upd_data2;
  logic                upd_valid1;
  logic                upd_valid2;
  logic                len_err1;
  logic                len_err2;
  logic                rti1;
  logic                rti2;

  // Driver side: JTAGG primitive plus application core.
  modport master (
    output JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2, cap_data1, cap_data2,
    input  JTDO1, JTDO2, upd_data1, upd_data2, upd_valid1, upd_valid2,
    input  len_err1, len_err2, rti1, rti2
  );

  // Engine side.
  modport slave (
    input  JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2, cap_data1, cap_data2,
    output JTDO1, JTDO2, upd_data1, upd_data2, upd_valid1, upd_valid2,
    output len_err1, len_err2, rti1, rti2
  );
endinterface

// File: rtl/jtag_user_dr_chan.sv
// One user data-register channel: capture/shift register, length counter,
// update holding register with strobe, sticky length error and TDO.
module jtag_user_dr_chan
  import jtag_user_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DR_WIDTH_DEF,
  parameter bit          STRICT_LEN = 1'b1,
  parameter int unsigned CNT_W      = cnt_w_f(DR_WIDTH)
) (
  input  logic                i_jtck,
  input  logic                i_jrstn,
  input  logic                i_tdi,
  input  logic                i_capture,
  input  logic                i_shift,
  input  logic                i_update,
  input  logic [DR_WIDTH-1:0] i_cap_data,
  output logic                o_tdo,
  output logic [DR_WIDTH-1:0] o_upd_data,
  output logic                o_upd_valid,
  output logic                o_len_err
);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(DR_WIDTH + 1);

  logic [DR_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [DR_WIDTH-1:0] r_upd_data;
  logic                r_upd_valid;
  logic                r_len_err;
  logic                w_len_ok;

  assign w_len_ok = !STRICT_LEN || (r_cnt == CntFull);

  // Capture loads the register and clears the count; shift moves LSB out first.
  always_ff @(posedge i_jtck or negedge i_jrstn) begin
    if (!i_jrstn) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_capture) begin
      r_shift <= i_cap_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= {i_tdi, r_shift[DR_WIDTH-1:1]};
      if (r_cnt != CntSat) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Commit on a correct-length update; otherwise flag it until the next good one.
  always_ff @(posedge i_jtck or negedge i_jrstn) begin
    if (!i_jrstn) begin
      r_upd_data  <= '0;
      r_upd_valid <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_upd_valid <= 1'b0;
      if (i_update) begin
        if (w_len_ok) begin
          r_upd_data  <= r_shift;
          r_upd_valid <= 1'b1;
          r_len_err   <= 1'b0;
        end else begin
          r_len_err   <= 1'b1;
        end
      end
    end
  end

  assign o_tdo       = r_shift[0];
  assign o_upd_data  = r_upd_data;
  assign o_upd_valid = r_upd_valid;
  assign o_len_err   = r_len_err;

endmodule

// File: rtl/jtag_dual_user_dr.sv
// Dual ER1/ER2 user data-register engine fed directly by JTAGG signals.
// Holds the shared active-channel register, JUPDATE edge detect and RTI strobes.
module jtag_dual_user_dr
  import jtag_user_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DR_WIDTH_DEF,
  parameter bit          STRICT_LEN = 1'b1,
  parameter int unsigned CNT_W      = cnt_w_f(DR_WIDTH)
) (
  input  logic                JTCK,
  input  logic                JRSTN,
  jtag_dual_user_dr_if.slave  bus
);

  logic       w_ce1;
  logic       w_ce2;
  logic       w_cap1;
  logic       w_cap2;
  logic       w_sh1;
  logic       w_sh2;
  logic       r_upd_q;
  logic       r_upd_q2;
  logic       w_upd_fire;
  logic       w_upd1;
  logic       w_upd2;
  ch_sel_e    r_active;
  ch_sel_e    w_active_d;
  logic [1:0] r_rti_q;
  logic [1:0] r_rti_q2;

  // Both enables high is illegal; channel 1 wins and channel 2 holds.
  assign w_ce1  = bus.JCE1;
  assign w_ce2  = bus.JCE2 & ~bus.JCE1;
  assign w_cap1 = w_ce1 & ~bus.JSHIFT;
  assign w_cap2 = w_ce2 & ~bus.JSHIFT;
  assign w_sh1  = w_ce1 & bus.JSHIFT;
  assign w_sh2  = w_ce2 & bus.JSHIFT;

  // JUPDATE is sampled first, then edge-detected, so a long Update-DR acts once.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_upd_q  <= 1'b0;
      r_upd_q2 <= 1'b0;
    end else begin
      r_upd_q  <= bus.JUPDATE;
      r_upd_q2 <= r_upd_q;
    end
  end

  assign w_upd_fire = r_upd_q & ~r_upd_q2;
  assign w_upd1     = w_upd_fire & (r_active == CH_1);
  assign w_upd2     = w_upd_fire & (r_active == CH_2);

  // Any update attempt consumes the capture; a new capture re-arms a channel.
  always_comb begin
    w_active_d = r_active;
    if (w_upd_fire) w_active_d = CH_NONE;
    if (w_cap1) begin
      w_active_d = CH_1;
    end else if (w_cap2) begin
      w_active_d = CH_2;
    end
  end

  // Active-channel register.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) r_active <= CH_NONE;
    else        r_active <= w_active_d;
  end

  // RTI edge detectors, one bit per channel.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_rti_q  <= '0;
      r_rti_q2 <= '0;
    end else begin
      r_rti_q  <= {bus.JRTI2, bus.JRTI1};
      r_rti_q2 <= r_rti_q;
    end
  end

  assign bus.rti1 = r_rti_q[0] & ~r_rti_q2[0];
  assign bus.rti2 = r_rti_q[1] & ~r_rti_q2[1];

  jtag_user_dr_chan #(
    .DR_WIDTH   (DR_WIDTH),
    .STRICT_LEN (STRICT_LEN),
    .CNT_W      (CNT_W)
  ) u_chan1 (
    .i_jtck      (JTCK),
    .i_jrstn     (JRSTN),
    .i_tdi       (bus.JTDI),
    .i_capture   (w_cap1),
    .i_shift     (w_sh1),
    .i_update    (w_upd1),
    .i_cap_data  (bus.cap_data1),
    .o_tdo       (bus.JTDO1),
    .o_upd_data  (bus.upd_data1),
    .o_upd_valid (bus.upd_valid1),
    .o_len_err   (bus.len_err1)
  );

  jtag_user_dr_chan #(
    .DR_WIDTH   (DR_WIDTH),
    .STRICT_LEN (STRICT_LEN),
    .CNT_W      (CNT_W)
  ) u_chan2 (
    .i_jtck      (JTCK),
    .i_jrstn     (JRSTN),
    .i_tdi       (bus.JTDI),
    .i_capture   (w_cap2),
    .i_shift     (w_sh2),
    .i_update    (w_upd2),
    .i_cap_data  (bus.cap_data2),
    .o_tdo       (bus.JTDO2),
    .o_upd_data  (bus.upd_data2),
    .o_upd_valid (bus.upd_valid2),
    .o_len_err   (bus.len_err2)
  );

endmodule

// File: tb/tb_jtag_dual_user_dr.sv
// Directed bench: a strict-length instance and a lenient one share all stimulus.
module tb_jtag_dual_user_dr;

  logic jtck;
  logic jrstn;
  int   checks;
  int   failures;

  jtag_dual_user_dr_if #(.DR_WIDTH(8)) bs ();
  jtag_dual_user_dr_if #(.DR_WIDTH(8)) bl ();

  assign bl.JTDI      = bs.JTDI;
  assign bl.JSHIFT    = bs.JSHIFT;
  assign bl.JUPDATE   = bs.JUPDATE;
  assign bl.JCE1      = bs.JCE1;
  assign bl.JCE2      = bs.JCE2;
  assign bl.JRTI1     = bs.JRTI1;
  assign bl.JRTI2     = bs.JRTI2;
  assign bl.cap_data1 = bs.cap_data1;
  assign bl.cap_data2 = bs.cap_data2;

  jtag_dual_user_dr #(.DR_WIDTH(8), .STRICT_LEN(1'b1)) dut_s (
    .JTCK  (jtck),
    .JRSTN (jrstn),
    .bus   (bs)
  );

  jtag_dual_user_dr #(.DR_WIDTH(8), .STRICT_LEN(1'b0)) dut_l (
    .JTCK  (jtck),
    .JRSTN (jrstn),
    .bus   (bl)
  );

  initial jtck = 1'b0;
  always #5 jtck = ~jtck;

  task automatic tick();
    @(posedge jtck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int ch, input logic [7:0] d);
    bs.JCE1   = (ch == 1);
    bs.JCE2   = (ch == 2);
    bs.JSHIFT = 1'b0;
    if (ch == 1) bs.cap_data1 = d;
    else         bs.cap_data2 = d;
    tick();
  endtask

  task automatic shift_in(input logic [15:0] bits, input int n);
    bs.JSHIFT = 1'b1;
    for (int i = 0; i < n; i++) begin
      bs.JTDI = bits[i];
      tick();
    end
    bs.JSHIFT = 1'b0;
    bs.JCE1   = 1'b0;
    bs.JCE2   = 1'b0;
    bs.JTDI   = 1'b0;
  endtask

  // Holds JUPDATE for n_high edges and counts strobes over a 6-cycle window.
  task automatic pulse_update(input int n_high, output int v1, output int v2,
                              output int l1, output int l2);
    v1 = 0; v2 = 0; l1 = 0; l2 = 0;
    bs.JUPDATE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == n_high) bs.JUPDATE = 1'b0;
      tick();
      if (bs.upd_valid1) v1++;
      if (bs.upd_valid2) v2++;
      if (bl.upd_valid1) l1++;
      if (bl.upd_valid2) l2++;
    end
    bs.JUPDATE = 1'b0;
  endtask

  initial begin
    int          v1, v2, l1, l2, w1, w2, m1, m2, r1, r2;
    logic [7:0]  cap_pat;
    logic [7:0]  tdi_pat;
    checks   = 0;
    failures = 0;
    jrstn    = 1'b0;
    bs.JTDI = 1'b0; bs.JSHIFT = 1'b0; bs.JUPDATE = 1'b0;
    bs.JCE1 = 1'b0; bs.JCE2 = 1'b0; bs.JRTI1 = 1'b0; bs.JRTI2 = 1'b0;
    bs.cap_data1 = '0; bs.cap_data2 = '0;
    tick();
    tick();
    check("rst_upd_data1", bs.upd_data1, 8'h00);
    check("rst_jtdo1", bs.JTDO1, 1'b0);
    check("rst_len_err2", bs.len_err2, 1'b0);
    check("rst_rti1", bs.rti1, 1'b0);
    jrstn = 1'b1;
    tick();

    // 1: channel 1 normal path
    cap_pat = 8'hA5;
    tdi_pat = 8'h3C;
    capture(1, cap_pat);
    bs.JSHIFT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bs.JTDI = tdi_pat[i];
      check($sformatf("t1_jtdo1_bit%0d", i), bs.JTDO1, cap_pat[i]);
      tick();
    end
    bs.JSHIFT = 1'b0; bs.JCE1 = 1'b0; bs.JTDI = 1'b0;
    pulse_update(1, v1, v2, l1, l2);
    check("t1_upd_data1", bs.upd_data1, 8'h3C);
    check("t1_strobe1_count", v1, 1);
    check("t1_strobe2_count", v2, 0);
    check("t1_upd_data2", bs.upd_data2, 8'h00);
    check("t1_jtdo2", bs.JTDO2, 1'b0);
    check("t1_len_err1", bs.len_err1, 1'b0);

    // 2: short shift on channel 2, then a correct one
    capture(2, 8'h5A);
    shift_in(16'h001F, 5);
    pulse_update(1, v1, v2, l1, l2);
    check("t2_short_upd_data2", bs.upd_data2, 8'h00);
    check("t2_short_strobe2", v2, 0);
    check("t2_short_len_err2", bs.len_err2, 1'b1);
    check("t2_lenient_upd_data2", bl.upd_data2, 8'hFA);
    check("t2_lenient_strobe2", l2, 1);
    capture(2, 8'h00);
    shift_in(16'h00FF, 8);
    pulse_update(1, v1, v2, l1, l2);
    check("t2_good_upd_data2", bs.upd_data2, 8'hFF);
    check("t2_good_strobe2", v2, 1);
    check("t2_good_len_err2", bs.len_err2, 1'b0);

    // 3: long shift on channel 1; last 8 bits are 0x96
    capture(1, 8'h00);
    shift_in({6'd0, 8'h96, 2'b11}, 10);
    pulse_update(1, v1, v2, l1, l2);
    check("t3_long_len_err1", bs.len_err1, 1'b1);
    check("t3_long_upd_data1", bs.upd_data1, 8'h3C);
    check("t3_long_strobe1", v1, 0);
    check("t3_lenient_upd_data1", bl.upd_data1, 8'h96);
    check("t3_lenient_strobe1", l1, 1);
    check("t3_lenient_len_err1", bl.len_err1, 1'b0);

    // 4: update without capture
    capture(1, 8'h00);
    shift_in(16'h0081, 8);
    pulse_update(1, v1, v2, l1, l2);
    check("t4_good_upd_data1", bs.upd_data1, 8'h81);
    check("t4_good_len_err1", bs.len_err1, 1'b0);
    pulse_update(3, v1, v2, l1, l2);
    check("t4_hold_strobe1", v1, 0);
    check("t4_hold_upd_data1", bs.upd_data1, 8'h81);
    capture(1, 8'h00);
    shift_in(16'h0042, 8);
    pulse_update(1, v1, v2, l1, l2);
    pulse_update(1, w1, w2, l1, l2);
    check("t4_two_pulses_strobes", v1 + w1, 1);
    check("t4_two_pulses_upd_data1", bs.upd_data1, 8'h42);

    // 5: zero-length shift error, then reset mid-shift
    capture(2, 8'h33);
    bs.JCE2 = 1'b0;
    pulse_update(1, v1, v2, l1, l2);
    check("t5_zero_len_err2", bs.len_err2, 1'b1);
    check("t5_zero_len_strobe2", v2, 0);
    capture(1, 8'hFF);
    bs.JSHIFT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bs.JTDI = 1'b0;
      tick();
    end
    check("t5_pre_rst_jtdo1", bs.JTDO1, 1'b1);
    jrstn = 1'b0;
    #2;
    check("t5_rst_jtdo1", bs.JTDO1, 1'b0);
    check("t5_rst_upd_data1", bs.upd_data1, 8'h00);
    check("t5_rst_upd_data2", bs.upd_data2, 8'h00);
    check("t5_rst_len_err2", bs.len_err2, 1'b0);
    bs.JSHIFT = 1'b0; bs.JCE1 = 1'b0;
    tick();
    tick();
    jrstn = 1'b1;
    tick();
    pulse_update(1, v1, v2, l1, l2);
    check("t5_post_rst_strobe1", v1, 0);
    check("t5_post_rst_strobe2", v2, 0);
    check("t5_post_rst_len_err1", bs.len_err1, 1'b0);
    check("t5_post_rst_upd_data1", bs.upd_data1, 8'h00);

    // 6: RTI strobe on channel 2
    r1 = 0; r2 = 0; m1 = 0; m2 = 0;
    bs.JRTI2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bs.JRTI2 = 1'b0;
      tick();
      if (i == 0) m2 = int'(bs.rti2);
      if (bs.rti1) r1++;
      if (bs.rti2) r2++;
    end
    check("t6_rti2_first_cycle", m2, 1);
    check("t6_rti2_count", r2, 1);
    check("t6_rti1_count", r1, m1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
